// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p: round-robin sharing of one synchronous SRAM between two
// single-word read/write requesters. All outputs are registered.
module ram_arbiter_2p #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_last;
    logic          r_owner;
    logic          w_last_nxt;
    logic          w_owner_nxt;
    logic          w_any;
    logic          w_win;

    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata;
    logic          r_busy;
    logic          r_ram_cs;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_din;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_rvalid0;
    logic          w_rvalid1;
    logic [DW-1:0] w_rdata;
    logic          w_busy;
    logic          w_ram_cs;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [DW-1:0] w_ram_din;

    // A lone requester wins outright; on contention the one not served last wins.
    assign w_any = req0 | req1;
    assign w_win = (req0 & req1) ? ~r_last : req1;

    // State register: FSM state, arbitration history and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
            r_ram_cs   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_owner    <= w_owner_nxt;
            r_gnt0     <= w_gnt0;
            r_gnt1     <= w_gnt1;
            r_rvalid0  <= w_rvalid0;
            r_rvalid1  <= w_rvalid1;
            r_rdata    <= w_rdata;
            r_busy     <= w_busy;
            r_ram_cs   <= w_ram_cs;
            r_ram_we   <= w_ram_we;
            r_ram_addr <= w_ram_addr;
            r_ram_din  <= w_ram_din;
        end
    end

    // Next-state logic: accept in IDLE, writes finish in ACCESS, reads add RESP.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_owner_nxt = r_owner;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = ACCESS;
                    w_last_nxt  = w_win;
                    w_owner_nxt = w_win;
                end
            end
            // r_ram_we still holds the accepted command type during ACCESS.
            ACCESS:  w_state_nxt = r_ram_we ? IDLE : RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the registered SRAM pins, grants and read return.
    always_comb begin
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_rvalid0  = 1'b0;
        w_rvalid1  = 1'b0;
        w_rdata    = r_rdata;
        w_ram_cs   = 1'b0;
        w_ram_we   = 1'b0;
        w_ram_addr = r_ram_addr;
        w_ram_din  = r_ram_din;
        w_busy     = (w_state_nxt != IDLE);
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_ram_cs   = 1'b1;
                    w_ram_we   = w_win ? we1    : we0;
                    w_ram_addr = w_win ? addr1  : addr0;
                    w_ram_din  = w_win ? wdata1 : wdata0;
                    w_gnt0     = ~w_win;
                    w_gnt1     = w_win;
                end
            end
            // SRAM read data is only valid at this edge; capture it now.
            RESP: begin
                w_rdata   = ram_dout;
                w_rvalid0 = ~r_owner;
                w_rvalid1 = r_owner;
            end
            default: ;
        endcase
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata    = r_rdata;
    assign busy     = r_busy;
    assign ram_cs   = r_ram_cs;
    assign ram_we   = r_ram_we;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// tb_ram_arbiter_2p: directed bench for ram_arbiter_2p with a 16x8 SRAM model.
module tb_ram_arbiter_2p;

    logic       clk;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [7:0] rdata;
    logic       ram_cs, ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    int n_chk  = 0;
    int n_fail = 0;

    ram_arbiter_2p #(.AW(4), .DW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .gnt0     (gnt0),
        .rvalid0  (rvalid0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .gnt1     (gnt1),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .busy     (busy),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: registered read, 8'hEE stands in for X when not selected.
    logic [7:0] mem [16];
    logic       loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
            mem[1] <= 8'h04;
            mem[2] <= 8'h05;
            mem[5] <= 8'h33;
            loaded <= 1'b1;
        end else if (ram_cs && ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        if (ram_cs && !ram_we) ram_dout <= mem[ram_addr];
        else                   ram_dout <= 8'hEE;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        chk("gnt_mutex", 32'(gnt0 & gnt1), 32'd0);
        chk("rvalid_mutex", 32'(rvalid0 & rvalid1), 32'd0);
    endtask

    task automatic rd_cmd(input logic p, input logic [3:0] a, input logic [7:0] e);
        logic got;
        got = 1'b0;
        if (p) begin req1 = 1'b1; we1 = 1'b0; addr1 = a; end
        else   begin req0 = 1'b1; we0 = 1'b0; addr0 = a; end
        for (int k = 0; k < 8; k++) begin
            if (!got) begin
                cyc();
                if ((p ? gnt1 : gnt0) === 1'b1) got = 1'b1;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("rd_gnt", 32'(got), 32'd1);
        cyc();
        cyc();
        chk("rd_rvalid", 32'(p ? rvalid1 : rvalid0), 32'd1);
        chk("rd_data", 32'(rdata), 32'(e));
    endtask

    // r0 writes addr 5 while r1 reads addr 5; report who was granted first and the read value.
    task automatic mixed(input logic [7:0] wd, input logic exp_first, input logic [7:0] exp_rd);
        logic [1:0] first;
        logic       seen;
        logic [7:0] rd;
        first = 2'd2;
        seen  = 1'b0;
        rd    = 8'h00;
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h5; wdata0 = wd;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h5;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (gnt0) begin req0 = 1'b0; if (first == 2'd2) first = 2'd0; end
            if (gnt1) begin req1 = 1'b0; if (first == 2'd2) first = 2'd1; end
            if (rvalid1) begin seen = 1'b1; rd = rdata; end
        end
        chk("mixed_first", 32'(first), 32'(exp_first));
        chk("mixed_rvalid", 32'(seen), 32'd1);
        chk("mixed_rdata", 32'(rd), 32'(exp_rd));
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

        // Reset with random requests
        for (int i = 0; i < 2; i++) begin
            req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
            req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
            addr0 = 4'($urandom); addr1 = 4'($urandom);
            wdata0 = 8'($urandom); wdata1 = 8'($urandom);
            cyc();
            chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
            chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ram", 32'({ram_cs, ram_we, ram_addr, ram_din}), 32'd0);
            chk("rst_rdata", 32'(rdata), 32'd0);
        end
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        cyc();
        chk("idle_busy", 32'(busy), 32'd0);

        // Write then read on requester 0
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h3; wdata0 = 8'h06;
        cyc();
        chk("wr_gnt0", 32'(gnt0), 32'd1);
        chk("wr_gnt1", 32'(gnt1), 32'd0);
        chk("wr_cs_we", 32'({ram_cs, ram_we}), 32'd3);
        chk("wr_addr", 32'(ram_addr), 32'h3);
        chk("wr_din", 32'(ram_din), 32'h06);
        chk("wr_busy", 32'(busy), 32'd1);
        req0 = 1'b0;
        cyc();
        chk("wr_acc_gnt0", 32'(gnt0), 32'd0);
        chk("wr_acc_cs", 32'({ram_cs, ram_we}), 32'd0);
        chk("wr_acc_addr_hold", 32'(ram_addr), 32'h3);
        chk("wr_acc_busy", 32'(busy), 32'd0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h3;
        cyc();
        chk("rd_gnt0", 32'(gnt0), 32'd1);
        chk("rd_cs_we", 32'({ram_cs, ram_we}), 32'd2);
        req0 = 1'b0;
        cyc();
        chk("rd_acc_cs", 32'(ram_cs), 32'd0);
        chk("rd_acc_busy", 32'(busy), 32'd1);
        chk("rd_acc_rvalid", 32'(rvalid0), 32'd0);
        cyc();
        chk("rd_rvalid0", 32'(rvalid0), 32'd1);
        chk("rd_rdata", 32'(rdata), 32'h06);
        chk("rd_resp_busy", 32'(busy), 32'd0);
        cyc();
        chk("rd_rvalid0_clr", 32'(rvalid0), 32'd0);

        // Contention: both hold reads, grants alternate starting with requester 0
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h2;
        for (int i = 0; i < 12; i++) begin
            logic eg, ev, own;
            eg  = (i % 3 == 0);
            ev  = (i % 3 == 2);
            own = ((i / 3) % 2 == 1);
            cyc();
            chk("cont_gnt", 32'({gnt0, gnt1}), 32'({eg & ~own, eg & own}));
            chk("cont_rvalid", 32'({rvalid0, rvalid1}), 32'({ev & ~own, ev & own}));
            if (ev) chk("cont_rdata", 32'(rdata), own ? 32'h05 : 32'h04);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Single requester: four back-to-back writes, one grant every 2 cycles
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'h8; wdata1 = 8'hA0;
        for (int i = 0; i < 8; i++) begin
            logic eg;
            eg = (i % 2 == 0);
            cyc();
            chk("single_gnt1", 32'(gnt1), 32'(eg));
            chk("single_gnt0", 32'(gnt0), 32'd0);
            if (eg) begin
                chk("single_addr", 32'(ram_addr), 32'(8 + i / 2));
                chk("single_din", 32'(ram_din), 32'(8'hA0 + i / 2));
                addr1  = 4'(8 + i / 2 + 1);
                wdata1 = 8'(8'hA0 + i / 2 + 1);
                if (i == 6) req1 = 1'b0;
            end
        end
        rd_cmd(1'b0, 4'hA, 8'hA2);
        rd_cmd(1'b1, 4'hB, 8'hA3);

        // Reset on the RESP edge of a read
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h3;
        cyc();
        chk("rr_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        chk("rr_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_cs", 32'(ram_cs), 32'd0);
        rst = 1'b0;
        cyc();
        chk("rr_rvalid_after", 32'({rvalid0, rvalid1}), 32'd0);
        rd_cmd(1'b0, 4'h3, 8'h06);

        // Mixed: write wins first (fresh reset), then read wins first
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mixed(8'h08, 1'b0, 8'h08);
        rd_cmd(1'b0, 4'h5, 8'h08);
        mixed(8'h0C, 1'b1, 8'h08);
        rd_cmd(1'b1, 4'h5, 8'h0C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
